// File: rtl/cmp_seq_64.sv
// ---------------------------------------------------------------------------
// cmp_seq_64 -- slice-serial magnitude comparator
//
// Accepts two WIDTH-bit operands over a valid/ready handshake and compares
// them MSB-first, SLICE bits per clock, with great/equal/less cascade
// semantics. Signed compares are turned into unsigned ones at capture time
// by inverting the sign bit of both operands. The result is held over a
// valid/ready output handshake until consumed.
//
// Build option:
//   CMP_SEQ_EARLY_EXIT_EN  defined   -> stop at the first differing slice
//                                       (latency k = 1..N).
//                          undefined -> always walk all N slices; the first
//                                       differing slice latches the decision
//                                       (latency k = N, constant).
//   Results are identical in both builds.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   in_valid   in   operands valid
//   in_ready   out  block can accept operands (state IDLE)
//   a, b       in   WIDTH-bit operands
//   is_signed  in   1 = two's-complement compare, 0 = unsigned
//   greatin    in   cascade great, used when a == b
//   equalin    in   cascade equal, used when a == b
//   lessin     in   cascade less,  used when a == b
//   out_valid  out  result valid (state DONE)
//   out_ready  in   consumer accepts the result
//   great      out  a >  b
//   equal      out  a == b (or cascade pass-through)
//   less       out  a <  b
// ---------------------------------------------------------------------------
module cmp_seq_64 #(
    parameter int WIDTH = 64,   // must be a multiple of SLICE
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic             greatin,
    input  logic             equalin,
    input  logic             lessin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             great,
    output logic             equal,
    output logic             less
);

    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

    // Result vectors are ordered {great, equal, less}.
    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_LT = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // -----------------------------------------------------------------------
    // Registered operands, cascade inputs, slice index and result
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       cas_q;
    logic [IW-1:0]    idx, idx_nxt;
    logic [2:0]       res_q, res_nxt;
    logic             capture;

    // Sign bit mask: inverting the MSB of both operands maps two's-complement
    // ordering onto unsigned ordering, so the slice walk stays unsigned.
    logic [WIDTH-1:0] sign_flip;
    assign sign_flip = {is_signed, {(WIDTH-1){1'b0}}};

    // -----------------------------------------------------------------------
    // Slice views of the captured operands, selected by idx
    // -----------------------------------------------------------------------
    logic [SLICE-1:0] a_sl [N];
    logic [SLICE-1:0] b_sl [N];

    for (genvar s = 0; s < N; s++) begin : g_slice
        assign a_sl[s] = a_q[s*SLICE +: SLICE];
        assign b_sl[s] = b_q[s*SLICE +: SLICE];
    end

    logic [SLICE-1:0] cur_a, cur_b;
    logic             slice_gt, slice_lt, last_slice, slice_done;
    logic [2:0]       fin_res;

    assign cur_a      = a_sl[idx];
    assign cur_b      = b_sl[idx];
    assign slice_gt   = (cur_a > cur_b);
    assign slice_lt   = (cur_a < cur_b);
    assign last_slice = (idx == '0);

`ifdef CMP_SEQ_EARLY_EXIT_EN
    // Leave CMP at the first differing slice or after the last one.
    assign slice_done = slice_gt | slice_lt | last_slice;

    always_comb begin
        if (slice_gt)      fin_res = RES_GT;
        else if (slice_lt) fin_res = RES_LT;
        else               fin_res = cas_q;
    end
`else
    // Constant latency: every slice is visited. The first differing slice
    // (MSB-first) is remembered in dec_*; lower slices cannot overturn it.
    logic dec_valid_q, dec_gt_q;
    logic dec_valid_nxt, dec_gt_nxt;

    assign slice_done = last_slice;

    always_comb begin
        if (dec_valid_q)   fin_res = dec_gt_q ? RES_GT : RES_LT;
        else if (slice_gt) fin_res = RES_GT;
        else if (slice_lt) fin_res = RES_LT;
        else               fin_res = cas_q;
    end

    always_comb begin
        dec_valid_nxt = dec_valid_q;
        dec_gt_nxt    = dec_gt_q;
        if (capture) begin
            dec_valid_nxt = 1'b0;
            dec_gt_nxt    = 1'b0;
        end else if (state == CMP && !dec_valid_q && (slice_gt || slice_lt)) begin
            dec_valid_nxt = 1'b1;
            dec_gt_nxt    = slice_gt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_valid_q <= 1'b0;
            dec_gt_q    <= 1'b0;
        end else begin
            dec_valid_q <= dec_valid_nxt;
            dec_gt_q    <= dec_gt_nxt;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // FSM: next state, index and result
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned; a missing default here infers a latch.
        state_nxt = state;
        idx_nxt   = idx;
        res_nxt   = res_q;
        capture   = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    capture   = 1'b1;
                    idx_nxt   = IDX_TOP;
                    state_nxt = CMP;
                end
            end
            CMP: begin
                if (slice_done) begin
                    res_nxt   = fin_res;
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx - 1'b1;
                end
            end
            DONE: begin
                // Result bits keep their value after hand-off; only the
                // next DONE entry overwrites them.
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            cas_q <= '0;
            idx   <= '0;
            res_q <= '0;
        end else begin
            if (capture) begin
                a_q   <= a ^ sign_flip;
                b_q   <= b ^ sign_flip;
                cas_q <= {greatin, equalin, lessin};
            end
            idx   <= idx_nxt;
            res_q <= res_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign great     = res_q[2];
    assign equal     = res_q[1];
    assign less      = res_q[0];

endmodule
